// File: rtl/uart_frame_rx_if.sv
// Byte input and sample output bundle between uart_rx, the frame decoder and
// the capture path. The decoder uses the slave side.
interface uart_frame_rx_if #(
  parameter int SAMPLES_PER_FRAME = 2048
);
  localparam int IDX_W = $clog2(SAMPLES_PER_FRAME);

  logic [7:0]       uart_rx_data;
  logic             uart_rx_data_we;
  logic [23:0]      sample_data;
  logic             sample_we;
  logic [IDX_W-1:0] sample_index;
  logic             frame_start;
  logic             frame_done;
  logic             frame_err;
  logic [15:0]      frame_cnt;
  logic [7:0]       err_cnt;

  modport master (
    output uart_rx_data, uart_rx_data_we,
    input  sample_data, sample_we, sample_index,
    input  frame_start, frame_done, frame_err, frame_cnt, err_cnt
  );

  modport slave (
    input  uart_rx_data, uart_rx_data_we,
    output sample_data, sample_we, sample_index,
    output frame_start, frame_done, frame_err, frame_cnt, err_cnt
  );
endinterface

// File: rtl/uart_frame_rx.sv
// Hunts for the three-byte sync word in a UART byte stream, then rebuilds
// SAMPLES_PER_FRAME 24-bit samples sent LSB first, with an inter-byte timeout.
module uart_frame_rx #(
  parameter int         SAMPLES_PER_FRAME = 2048,
  parameter int         TIMEOUT_CYCLES    = 1000000,
  parameter logic [7:0] SYNC0             = 8'hAA,
  parameter logic [7:0] SYNC1             = 8'hBB,
  parameter logic [7:0] SYNC2             = 8'hCC
) (
  input logic            clk,
  input logic            reset_n,
  uart_frame_rx_if.slave bus
);
  localparam int IDX_W = $clog2(SAMPLES_PER_FRAME);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES_PER_FRAME - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {HUNT0, HUNT1, HUNT2, B0, B1, B2} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [TMR_W-1:0] r_timer;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_b0;
  logic [7:0]       r_b1;

  logic w_byte;
  logic w_timeout;
  logic w_start;
  logic w_sample;
  logic w_last;

  assign w_byte    = bus.uart_rx_data_we;
  // A byte arriving on the expiry cycle suppresses the timeout.
  assign w_timeout = (r_state != HUNT0) && !w_byte && (r_timer == TMR_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= HUNT0;
    else          r_state <= w_next_state;
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (w_byte) begin
      unique case (r_state)
        HUNT0: if (bus.uart_rx_data == SYNC0) w_next_state = HUNT1;
        HUNT1: begin
          if (bus.uart_rx_data == SYNC1)      w_next_state = HUNT2;
          else if (bus.uart_rx_data != SYNC0) w_next_state = HUNT0;
        end
        HUNT2: begin
          if (bus.uart_rx_data == SYNC2)      w_next_state = B0;
          else if (bus.uart_rx_data == SYNC0) w_next_state = HUNT1;
          else                                w_next_state = HUNT0;
        end
        B0:      w_next_state = B1;
        B1:      w_next_state = B2;
        B2:      w_next_state = (r_idx == IDX_LAST) ? HUNT0 : B0;
        default: w_next_state = HUNT0;
      endcase
    end else if (w_timeout) begin
      w_next_state = HUNT0;
    end
  end

  always_comb begin
    w_start  = 1'b0;
    w_sample = 1'b0;
    w_last   = 1'b0;
    if (w_byte) begin
      w_start  = (r_state == HUNT2) && (bus.uart_rx_data == SYNC2);
      w_sample = (r_state == B2);
      w_last   = (r_state == B2) && (r_idx == IDX_LAST);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer          <= '0;
      r_idx            <= '0;
      r_b0             <= '0;
      r_b1             <= '0;
      bus.sample_data  <= '0;
      bus.sample_we    <= 1'b0;
      bus.sample_index <= '0;
      bus.frame_start  <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.frame_cnt    <= '0;
      bus.err_cnt      <= '0;
    end else begin
      if (w_byte || w_timeout || r_state == HUNT0) r_timer <= '0;
      else                                         r_timer <= r_timer + 1'b1;

      if (w_byte && r_state == B0) r_b0 <= bus.uart_rx_data;
      if (w_byte && r_state == B1) r_b1 <= bus.uart_rx_data;

      if (w_start)                r_idx <= '0;
      else if (w_sample && !w_last) r_idx <= r_idx + 1'b1;

      if (w_sample) begin
        bus.sample_data  <= {bus.uart_rx_data, r_b1, r_b0};
        bus.sample_index <= r_idx;
      end
      bus.sample_we   <= w_sample;
      bus.frame_start <= w_start;
      bus.frame_done  <= w_last;
      bus.frame_err   <= w_timeout;

      if (w_last) bus.frame_cnt <= bus.frame_cnt + 1'b1;
      if (w_timeout && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed-plus-random bench for uart_frame_rx: a byte-stream model predicts
// samples and frame events, a negedge monitor compares them against the DUT.
module tb_uart_frame_rx;
  localparam int N = 2048;
  localparam int T = 16;
  localparam logic [7:0] S0 = 8'hAA;
  localparam logic [7:0] S1 = 8'hBB;
  localparam logic [7:0] S2 = 8'hCC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_rx_if #(.SAMPLES_PER_FRAME(N)) bus ();

  uart_frame_rx #(
    .SAMPLES_PER_FRAME(N), .TIMEOUT_CYCLES(T),
    .SYNC0(S0), .SYNC1(S1), .SYNC2(S2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic [23:0] data;
    int          idx;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Model state: last two bytes seen while hunting, payload assembly in a frame.
  bit          m_in_frame = 0;
  int          m_hist = 0;
  logic [7:0]  m_h1, m_h0;
  int          m_pay = 0;
  logic [23:0] m_acc;
  int exp_starts, exp_dones, exp_errs, exp_fcnt, exp_ecnt, exp_start_cyc;
  int obs_starts, obs_dones, obs_errs, obs_start_cyc;
  bit p_start, p_done, p_err;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, input int strobe_cyc);
    exp_t e;
    if (!m_in_frame) begin
      if (m_hist >= 2 && m_h1 == S0 && m_h0 == S1 && b == S2) begin
        m_in_frame    = 1;
        m_pay         = 0;
        m_hist        = 0;
        exp_starts++;
        exp_start_cyc = strobe_cyc;
      end else begin
        m_h1 = m_h0;
        m_h0 = b;
        m_hist++;
      end
    end else begin
      m_acc[8*(m_pay % 3) +: 8] = b;
      m_pay++;
      if (m_pay % 3 == 0) begin
        e.data = m_acc;
        e.idx  = m_pay / 3 - 1;
        e.last = (e.idx == N - 1);
        exp_q.push_back(e);
        if (e.last) begin
          m_in_frame = 0;
          m_hist     = 0;
          exp_dones++;
          exp_fcnt   = (exp_fcnt + 1) % 65536;
        end
      end
    end
  endfunction

  function automatic void model_abort(input bit with_err);
    m_in_frame = 0;
    m_hist     = 0;
    if (with_err) begin
      exp_errs++;
      if (exp_ecnt < 255) exp_ecnt++;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.frame_start) begin
        obs_starts++;
        obs_start_cyc = cyc;
      end
      if (bus.frame_done) obs_dones++;
      if (bus.frame_err)  obs_errs++;
      check("pulse_width", {p_start & bus.frame_start, p_done & bus.frame_done,
                            p_err & bus.frame_err}, 0);
      if (bus.sample_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample_data", bus.sample_data, e.data);
          check("sample_index", bus.sample_index, e.idx);
          check("frame_done_on_last", bus.frame_done, e.last);
        end
      end else begin
        check("frame_done_without_we", bus.frame_done, 0);
      end
      p_start = bus.frame_start;
      p_done  = bus.frame_done;
      p_err   = bus.frame_err;
    end else begin
      p_start = 0;
      p_done  = 0;
      p_err   = 0;
    end
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    bus.uart_rx_data    = b;
    bus.uart_rx_data_we = 1'b1;
    model_byte(b, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.uart_rx_data_we = 1'b0;
    end
  endtask

  // Occasional short gaps keep well inside the timeout window.
  task automatic send(input logic [7:0] b);
    drive(b);
    if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 4));
  endtask

  task automatic send_sample(input logic [23:0] v);
    send(v[7:0]);
    send(v[15:8]);
    send(v[23:16]);
  endtask

  // kind 0: k*0x010203; kind 1: random; kind 2: random with sample 0 = 0xCCBBAA
  task automatic send_frame(input int kind);
    logic [23:0] v;
    drive(S0);
    drive(S1);
    drive(S2);
    for (int k = 0; k < N; k++) begin
      if (kind == 0)                v = 24'(k * 32'h010203);
      else if (kind == 2 && k == 0) v = 24'hCCBBAA;
      else                          v = 24'($urandom);
      send_sample(v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n             = 1'b0;
    bus.uart_rx_data_we = 1'b0;
    model_abort(0);
    exp_q.delete();
    exp_starts = 0; exp_dones = 0; exp_errs = 0; exp_fcnt = 0; exp_ecnt = 0;
    obs_starts = 0; obs_dones = 0; obs_errs = 0;
    exp_start_cyc = -1; obs_start_cyc = -2;
    #1;
    check("rst_sample_data", bus.sample_data, 0);
    check("rst_counters", {bus.frame_cnt, bus.err_cnt}, 0);
    check("rst_flags", {bus.sample_we, bus.sample_index, bus.frame_start,
                        bus.frame_done, bus.frame_err}, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_flags", {bus.sample_we, bus.frame_start, bus.frame_done,
                             bus.frame_err, bus.frame_cnt, bus.err_cnt}, 0);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_end(input string name);
    idle(4);
    $display("step %s: frames=%0d errs=%0d", name, bus.frame_cnt, bus.err_cnt);
    check("queue_drained", exp_q.size(), 0);
    check("frame_start_count", obs_starts, exp_starts);
    check("frame_done_count", obs_dones, exp_dones);
    check("frame_err_count", obs_errs, exp_errs);
    check("frame_cnt", bus.frame_cnt, exp_fcnt);
    check("err_cnt", bus.err_cnt, exp_ecnt);
  endtask

  initial begin
    bus.uart_rx_data    = '0;
    bus.uart_rx_data_we = 1'b0;

    // Full frame with arithmetic sample pattern
    do_reset();
    send_frame(0);
    test_end("ramp_frame");
    check("ramp_frame_cnt_is_1", bus.frame_cnt, 1);

    // Garbage and repeated SYNC0 before the sync word; start latency
    do_reset();
    drive(8'h12);
    drive(S0);
    send_frame(1);
    check("frame_start_latency", obs_start_cyc, exp_start_cyc);
    test_end("preamble");

    // Broken sync then sync, payload that looks like sync
    do_reset();
    drive(S0); drive(S1); drive(8'h00);
    send_frame(2);
    test_end("no_resync");

    // Timeout exactly at the limit while hunting, then mid-frame, then recovery
    do_reset();
    drive(S0); drive(S1);
    idle(T);
    model_abort(1);
    drive(S0); drive(S1); drive(S2);
    for (int i = 0; i < 5; i++) drive(8'($urandom));
    idle(20);
    model_abort(1);
    send_frame(1);
    test_end("timeout");

    // Byte strobe lands on the expiry cycle in hunt and payload states
    do_reset();
    drive(S0); idle(T - 1);
    drive(S1); idle(T - 1);
    drive(S2);
    for (int k = 0; k < N; k++) begin
      send_sample(24'($urandom));
      if (k == 1 || k == N - 2) idle(T - 1);
    end
    test_end("expiry_race");

    // Reset in the middle of a frame, then a clean frame
    do_reset();
    drive(S0); drive(S1); drive(S2);
    for (int k = 0; k < 100; k++) send_sample(24'($urandom));
    drive(8'h55);
    idle(2);
    check("pre_reset_drained", exp_q.size(), 0);
    do_reset();
    send_frame(1);
    test_end("reset_mid_frame");

    // Error counter saturates
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive(S0);
      idle(T);
      model_abort(1);
    end
    test_end("err_saturate");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Receive-side decoder for the microphone sample stream sent over UART.
- Consumes bytes from a UART receiver, hunts for the sync sequence 0xAA 0xBB 0xCC, then reassembles SAMPLES_PER_FRAME 24-bit signed samples, each sent as 3 bytes LSB first.
- Emits one write strobe per sample, plus frame start/done/error pulses.
- Sits between uart_rx and the capture memory / display path.

Parameters:
- SAMPLES_PER_FRAME, 2048, samples per frame after sync; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 1000000, clock cycles allowed between bytes once a frame is in progress; must be at least 2.
- SYNC0, 8'hAA, first sync byte.
- SYNC1, 8'hBB, second sync byte.
- SYNC2, 8'hCC, third sync byte.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- uart_rx_data  input  8  received byte, valid only when uart_rx_data_we=1
- uart_rx_data_we  input  1  one-cycle strobe per received byte
- sample_data  output  24  assembled sample; held until the next sample
- sample_we  output  1  one-cycle strobe, sample_data/sample_index valid
- sample_index  output  clog2(SAMPLES_PER_FRAME)  index of the current sample in the frame
- frame_start  output  1  one-cycle pulse when SYNC2 is accepted
- frame_done  output  1  one-cycle pulse, coincident with sample_we of the last sample
- frame_err  output  1  one-cycle pulse on inter-byte timeout
- frame_cnt  output  16  completed frames, wraps at 0xFFFF
- err_cnt  output  8  timeouts, saturates at 0xFF

Behaviour:
- Reset (reset_n=0, async)
  - All outputs go to 0, state goes to HUNT0, timeout counter goes to 0, byte shift register goes to 0.
  - Reset mid-frame discards the partial frame; no frame_done or frame_err is issued.
- All outputs are registered. Latency: byte strobe at cycle N gives the output pulse at cycle N+1.
- States; transitions happen only on uart_rx_data_we=1 unless noted:
  - HUNT0: SYNC0 -> HUNT1; any other byte stays in HUNT0.
  - HUNT1: SYNC1 -> HUNT2; SYNC0 stays in HUNT1; any other byte -> HUNT0.
  - HUNT2: SYNC2 -> B0, pulse frame_start, clear sample counter; SYNC0 -> HUNT1; any other byte -> HUNT0.
  - B0: latch byte into bits [7:0], go to B1.
  - B1: latch byte into bits [15:8], go to B2.
  - B2: form sample = {byte, [15:8], [7:0]}.
    - Drive sample_data and sample_index = counter, pulse sample_we.
    - If counter = SAMPLES_PER_FRAME-1: also pulse frame_done, increment frame_cnt, go to HUNT0.
    - Otherwise: increment counter, go to B0.
- Payload bytes are never compared against sync values; 0xAA inside a sample is data.
- Timeout
  - The counter runs in HUNT1, HUNT2, B0, B1 and B2. It clears on every byte strobe and is held at 0 in HUNT0.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: pulse frame_err, increment err_cnt (saturating), go to HUNT0, clear the counter.
  - A byte strobe in the same cycle as expiry wins: the byte is processed and no error is raised.
- sample_index width is clog2(SAMPLES_PER_FRAME); the counter never wraps inside a frame.
- Back-to-back bytes (strobe every cycle) must be accepted with no loss.
- frame_start, sample_we, frame_done and frame_err are never high for more than 1 cycle.
- No backpressure: the downstream consumer must accept every sample_we.

Test Plan:
- Sync plus 2048 samples, sample k = k*0x010203 (mod 2^24), bytes LSB first -> frame_start once; 2048 sample_we with matching data; sample_index 0..2047; frame_done with index 2047; frame_cnt=1; err_cnt=0.
- Preamble 0x12, 0xAA, 0xAA, 0xBB, 0xCC, then a frame -> frame_start asserted exactly 1 cycle after the 0xCC strobe; first sample correct.
- Preamble 0xAA 0xBB 0x00 0xAA 0xBB 0xCC, then a frame whose sample 0 is 0xCCBBAA -> sample_data=0xCCBBAA at index 0, no resync.
- With TIMEOUT_CYCLES=16, stop after 5 payload bytes, idle 20 cycles -> frame_err pulses once; err_cnt=1; no frame_done; a following full frame decodes normally and frame_cnt=1.
- Byte strobe on exactly the expiry cycle -> no frame_err; the frame completes.
- Assert reset_n=0 mid-frame at sample 100, then release and send a full frame -> all outputs 0 during reset; frame_cnt=1 after; err_cnt=0.
